// File: rtl/mux_rr_arbiter_2to1.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux with valid/ready on all sides.
// Optional grant counters are enabled by defining ARB_STATS_EN.
module mux_rr_arbiter_2to1 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready
`ifdef ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              load_en;
  logic              grant_vld;
  logic              grant;
  logic              xfer;
  logic [DATA_W-1:0] out_data_r;
  logic              out_sel_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = (state == EMPTY) || out_ready;
    grant_vld = in0_valid || in1_valid;
    grant     = 1'b0;
    if (in0_valid && in1_valid) begin
      grant = ~last_grant;
    end else if (in1_valid) begin
      grant = 1'b1;
    end
    xfer      = load_en && grant_vld;
    // Readys are held low while in reset so no acceptance is signalled for a word that cannot load.
    in0_ready = rst_n && xfer && !grant && in0_valid;
    in1_ready = rst_n && xfer &&  grant && in1_valid;
    if (xfer) begin
      state_nxt = FULL;
    end else if (state == FULL && out_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= '0;
      out_sel_r  <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      out_data_r <= grant ? in1_data : in0_data;
      out_sel_r  <= grant;
      last_grant <= grant;
    end
  end

  assign out_valid = (state == FULL);
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Clear takes priority over a same-cycle transfer; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (stats_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (xfer) begin
      if (!grant && cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
      if ( grant && cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter_2to1.sv
// Directed self-checking bench for mux_rr_arbiter_2to1 (stats checks run when ARB_STATS_EN is defined).
module tb_mux_rr_arbiter_2to1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sel;
  logic       out_ready;
`ifdef ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mux_rr_arbiter_2to1 #(.DATA_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [7:0] exp_d [6] = '{8'd1, 8'd11, 8'd2, 8'd12, 8'd3, 8'd13};
  logic       exp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'hA5; in1_data = 8'h5A;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    // Reset held with both requesters valid
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_in0_ready", 32'(in0_ready), 32'd0);
    chk("rst_in1_ready", 32'(in1_ready), 32'd0);
    rst_n = 1'b1; settle();
    chk("first_in0_ready", 32'(in0_ready), 32'd1);
    chk("first_in1_ready", 32'(in1_ready), 32'd0);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0; settle();
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_data",  32'(out_data),  32'hA5);
    chk("first_out_sel",   32'(out_sel),   32'd0);
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_data_hold", 32'(out_data),  32'hA5);

    // Single requester on in1
    in1_valid = 1'b1; in1_data = 8'h3C; settle();
    chk("single_in1_ready0", 32'(in1_ready), 32'd1);
    chk("single_in0_ready0", 32'(in0_ready), 32'd0);
    tick();
    in1_data = 8'h3D; settle();
    chk("single_data0",      32'(out_data),  32'h3C);
    chk("single_sel0",       32'(out_sel),   32'd1);
    chk("single_in1_ready1", 32'(in1_ready), 32'd1);
    chk("single_in0_ready1", 32'(in0_ready), 32'd0);
    tick();
    in1_valid = 1'b0; settle();
    chk("single_data1",  32'(out_data),  32'h3D);
    chk("single_valid1", 32'(out_valid), 32'd1);
    tick();
    chk("single_drain", 32'(out_valid), 32'd0);

    // Tie alternation at full throughput
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'd1; in1_data = 8'd11;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("tie_in0_ready", 32'(in0_ready), 32'(!exp_s[i]));
      chk("tie_in1_ready", 32'(in1_ready), 32'(exp_s[i]));
      tick();
      chk("tie_out_valid", 32'(out_valid), 32'd1);
      chk("tie_out_data",  32'(out_data),  32'(exp_d[i]));
      chk("tie_out_sel",   32'(out_sel),   32'(exp_s[i]));
      if (!exp_s[i]) begin
        if (in0_data == 8'd3) in0_valid = 1'b0; else in0_data = in0_data + 8'd1;
      end else begin
        if (in1_data == 8'd13) in1_valid = 1'b0; else in1_data = in1_data + 8'd1;
      end
    end

    // Backpressure
    in0_valid = 1'b1; in0_data = 8'h77; in1_valid = 1'b0; settle();
    chk("bp_load_in0_ready", 32'(in0_ready), 32'd1);
    tick();
    out_ready = 1'b0; in0_data = 8'h88; in1_valid = 1'b1; in1_data = 8'h99;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_in0_ready", 32'(in0_ready), 32'd0);
      chk("bp_in1_ready", 32'(in1_ready), 32'd0);
      tick();
      chk("bp_out_data",  32'(out_data),  32'h77);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; settle();
    chk("bp_release_in1_ready", 32'(in1_ready), 32'd1);
    chk("bp_release_in0_ready", 32'(in0_ready), 32'd0);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    chk("bp_release_data",  32'(out_data),  32'h99);
    chk("bp_release_sel",   32'(out_sel),   32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd1);

    // Mid-operation asynchronous reset
    #2 rst_n = 1'b0; settle();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_out_sel",   32'(out_sel),   32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'hC1; in1_data = 8'hC2; settle();
    chk("mid_rst_tie_in0_ready", 32'(in0_ready), 32'd1);
    chk("mid_rst_tie_in1_ready", 32'(in1_ready), 32'd0);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk("mid_rst_tie_data", 32'(out_data), 32'hC1);
    chk("mid_rst_tie_sel",  32'(out_sel),  32'd0);

`ifdef ARB_STATS_EN
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    chk("stats_clr_cnt0", 32'(grant_cnt0), 32'd0);
    in0_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in0_valid = 1'b0; in1_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    in1_valid = 1'b0;
    chk("stats_cnt0", 32'(grant_cnt0), 32'd4);
    chk("stats_cnt1", 32'(grant_cnt1), 32'd3);
    in0_valid = 1'b1; stats_clr = 1'b1; tick();
    in0_valid = 1'b0; stats_clr = 1'b0;
    chk("stats_clr_win_cnt0", 32'(grant_cnt0), 32'd0);
    chk("stats_clr_win_cnt1", 32'(grant_cnt1), 32'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
